// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - instruction memory read bus between fetch and IM
interface if_fetch_if #(
    parameter int PC_W = 16
) ();
    logic [PC_W-1:0] im_addr;
    logic            im_rd_en;
    logic [31:0]     im_rdata;

    modport master (
        output im_addr,
        output im_rd_en,
        input  im_rdata
    );

    modport slave (
        input  im_addr,
        input  im_rd_en,
        output im_rdata
    );
endinterface

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: PC, IM read, wrong-path squash, next-PC pipe
module if_fetch #(
    parameter int          PC_W      = 16,
    parameter logic [31:0] NOP_INSTR = 32'h5800_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_IM_ID,
    input  logic            stall_ID_EX,
    input  logic            flow_change_ID_EX,
    input  logic [PC_W-1:0] dst_ID_EX,
    if_fetch_if.master      im,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] nxt_pc_ID_EX
);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] nxt_pc_IF;
    logic [PC_W-1:0] nxt_pc_IM_ID;
    logic            vld;
    logic            rd_en;

    assign pc_inc = pc + PC_W'(1);
    // A redirect must re-read even when decode is stalled so the old word is replaced.
    assign rd_en  = !stall_IM_ID | flow_change_ID_EX;

    assign im.im_addr  = pc;
    assign im.im_rd_en = rd_en;
    assign instr       = vld ? im.im_rdata : NOP_INSTR;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc           <= '0;
            vld          <= 1'b0;
            nxt_pc_IF    <= '0;
            nxt_pc_IM_ID <= '0;
            nxt_pc_ID_EX <= '0;
        end else begin
            if (flow_change_ID_EX)
                pc <= dst_ID_EX;
            else if (!stall_IM_ID)
                pc <= pc_inc;

            // The word latched at the redirect edge is wrong-path; decode's flush misses it.
            if (flow_change_ID_EX)
                vld <= 1'b0;
            else if (rd_en)
                vld <= 1'b1;

            if (rd_en)
                nxt_pc_IF <= pc_inc;
            if (!stall_IM_ID)
                nxt_pc_IM_ID <= nxt_pc_IF;
            if (!stall_ID_EX)
                nxt_pc_ID_EX <= nxt_pc_IM_ID;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed self-checking bench for if_fetch
module tb_if_fetch;
    localparam int          PC_W = 16;
    localparam logic [31:0] NOP  = 32'h5800_0000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            stall_IM_ID;
    logic            stall_ID_EX;
    logic            flow_change_ID_EX;
    logic [PC_W-1:0] dst_ID_EX;
    logic [31:0]     instr;
    logic [PC_W-1:0] nxt_pc_ID_EX;

    int errors = 0;
    int checks = 0;

    if_fetch_if #(.PC_W(PC_W)) bus ();

    if_fetch #(.PC_W(PC_W), .NOP_INSTR(NOP)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_IM_ID       (stall_IM_ID),
        .stall_ID_EX       (stall_ID_EX),
        .flow_change_ID_EX (flow_change_ID_EX),
        .dst_ID_EX         (dst_ID_EX),
        .im                (bus.master),
        .instr             (instr),
        .nxt_pc_ID_EX      (nxt_pc_ID_EX)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
        return 32'hA000_0000 + {16'h0000, a};
    endfunction

    // Synchronous-read IM with one-cycle latency; holds data when not enabled.
    initial bus.im_rdata = 32'h0;
    always @(posedge clk)
        if (bus.im_rd_en)
            bus.im_rdata <= mem_word(bus.im_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n             = 1'b0;
        stall_IM_ID       = 1'b0;
        stall_ID_EX       = 1'b0;
        flow_change_ID_EX = 1'b0;
        dst_ID_EX         = '0;

        step();
        step();
        check("rst_addr",  32'(bus.im_addr), 32'h0);
        check("rst_instr", instr, NOP);
        check("rst_npc",   32'(nxt_pc_ID_EX), 32'h0);
        check("rst_rden",  32'(bus.im_rd_en), 32'h1);

        rst_n = 1'b1;
        step();
        check("first_instr", instr, mem_word(16'h0000));
        check("first_addr",  32'(bus.im_addr), 32'h1);

        for (int i = 1; i <= 4; i++) begin
            step();
            check("line_instr", instr, mem_word(PC_W'(i)));
            check("line_addr",  32'(bus.im_addr), 32'(i + 1));
            if (i >= 2)
                check("line_npc", 32'(nxt_pc_ID_EX), 32'(i - 1));
        end

        stall_IM_ID = 1'b1;
        #1;
        check("stall_rden0", 32'(bus.im_rd_en), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr",  32'(bus.im_addr), 32'h5);
            check("stall_instr", instr, mem_word(16'h0004));
            check("stall_rden",  32'(bus.im_rd_en), 32'h0);
        end
        stall_IM_ID = 1'b0;
        step();
        check("unstall_instr", instr, mem_word(16'h0005));
        check("unstall_addr",  32'(bus.im_addr), 32'h6);

        for (int k = 0; k < 20 && bus.im_addr != 16'h0010; k++)
            step();
        check("reach_10", 32'(bus.im_addr), 32'h10);

        flow_change_ID_EX = 1'b1;
        dst_ID_EX         = 16'h0100;
        step();
        flow_change_ID_EX = 1'b0;
        check("redir_nop",  instr, NOP);
        check("redir_addr", 32'(bus.im_addr), 32'h100);
        step();
        check("redir_instr", instr, mem_word(16'h0100));
        check("redir_addr1", 32'(bus.im_addr), 32'h101);

        stall_IM_ID       = 1'b1;
        flow_change_ID_EX = 1'b1;
        dst_ID_EX         = 16'h0040;
        #1;
        check("sredir_rden", 32'(bus.im_rd_en), 32'h1);
        step();
        flow_change_ID_EX = 1'b0;
        check("sredir_nop0",  instr, NOP);
        check("sredir_addr0", 32'(bus.im_addr), 32'h40);
        for (int i = 0; i < 2; i++) begin
            step();
            check("sredir_nop",  instr, NOP);
            check("sredir_addr", 32'(bus.im_addr), 32'h40);
            check("sredir_rden0", 32'(bus.im_rd_en), 32'h0);
        end
        stall_IM_ID = 1'b0;
        step();
        check("sredir_instr", instr, mem_word(16'h0040));
        check("sredir_addr1", 32'(bus.im_addr), 32'h41);

        flow_change_ID_EX = 1'b1;
        dst_ID_EX         = 16'hFFFF;
        step();
        flow_change_ID_EX = 1'b0;
        check("wrap_pre", 32'(bus.im_addr), 32'hFFFF);
        step();
        check("wrap_addr",  32'(bus.im_addr), 32'h0);
        check("wrap_instr", instr, mem_word(16'hFFFF));
        step();
        check("wrap_next", instr, mem_word(16'h0000));

        rst_n = 1'b0;
        step();
        check("mrst_instr", instr, NOP);
        check("mrst_addr",  32'(bus.im_addr), 32'h0);
        check("mrst_npc",   32'(nxt_pc_ID_EX), 32'h0);
        rst_n = 1'b1;
        step();
        check("mrst_first", instr, mem_word(16'h0000));
        check("mrst_addr1", 32'(bus.im_addr), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
